// File: rtl/axis_channel_load_sequencer_if.sv
// Command, stream-handshake and status bundle of the channel load sequencer.
// The sequencer binds the slave modport and the command/stream source binds the master modport.
interface axis_channel_load_sequencer_if #(
  parameter int NUM_CH = 16,
  parameter int CH_W   = 4,
  parameter int BEAT_W = 16
);
  // Handshakes: a transfer happens on a clock edge where valid and ready are both high.
  // cmd_valid/cmd_ready move one command. up_tvalid/up_tready is the upstream stream port.
  // sel_tvalid/sel_tready is the router-side stream port.
  logic [CH_W-1:0]   cmd_channel;
  logic [BEAT_W-1:0] cmd_beats;
  logic              cmd_valid;
  logic              cmd_ready;
  logic              abort;
  logic              up_tvalid;
  logic              up_tready;
  logic              sel_tvalid;
  logic              sel_tready;
  logic [NUM_CH-1:0] channel_select;
  logic              busy;
  logic              done;
  logic [CH_W-1:0]   done_channel;
  logic [BEAT_W-1:0] beats_xferred;
  logic              err_timeout;
  logic              err_aborted;
  logic              err_cmd;
  logic [1:0]        state;

  modport slave (
    input  cmd_channel, cmd_beats, cmd_valid, abort, up_tvalid, sel_tready,
    output cmd_ready, up_tready, sel_tvalid, channel_select, busy, done,
           done_channel, beats_xferred, err_timeout, err_aborted, err_cmd, state
  );

  modport master (
    output cmd_channel, cmd_beats, cmd_valid, abort, up_tvalid, sel_tready,
    input  cmd_ready, up_tready, sel_tvalid, channel_select, busy, done,
           done_channel, beats_xferred, err_timeout, err_aborted, err_cmd, state
  );
endinterface

// File: rtl/axis_channel_load_sequencer.sv
// Loads a counted burst of stream beats into one router channel: drives the one-hot select,
// gates the upstream handshake while streaming, and reports completion, timeout or abort.
module axis_channel_load_sequencer #(
  parameter int NUM_CH  = 16,
  parameter int CH_W    = 4,
  parameter int BEAT_W  = 16,
  parameter int TIMEOUT = 100000,
  parameter int TO_W    = 20
) (
  input  logic                          clk,
  input  logic                          rst,
  axis_channel_load_sequencer_if.slave  bus
);
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ARM    = 2'd1;
  localparam logic [1:0] S_STREAM = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  logic [1:0]        state;
  logic [CH_W-1:0]   ch_q;
  logic [CH_W-1:0]   done_ch_q;
  logic [BEAT_W-1:0] target_q;
  logic [BEAT_W-1:0] count_q;
  logic [TO_W-1:0]   stall_q;
  logic [NUM_CH-1:0] select_q;
  logic              done_q;
  logic              err_to_q;
  logic              err_ab_q;
  logic              err_cmd_q;

  logic              streaming;
  logic              beat;
  logic              last_beat;
  logic              timeout_hit;
  logic              ch_bad;
  logic              cmd_bad;
  logic [BEAT_W-1:0] count_inc;
  logic [TO_W-1:0]   stall_inc;

  // Only an index width wider than the channel count can name a missing channel.
  if (NUM_CH < (1 << CH_W)) begin : g_ch_range
    assign ch_bad = (32'(bus.cmd_channel) >= NUM_CH);
  end else begin : g_ch_full
    assign ch_bad = 1'b0;
  end

  assign cmd_bad     = (bus.cmd_beats == '0) || ch_bad;
  assign streaming   = (state == S_STREAM);
  assign beat        = streaming && bus.up_tvalid && bus.sel_tready;
  assign count_inc   = count_q + 1'b1;
  assign stall_inc   = stall_q + 1'b1;
  assign last_beat   = beat && (count_inc == target_q);
  assign timeout_hit = streaming && !beat && (TIMEOUT != 0) && (stall_inc == TO_W'(TIMEOUT));

  // The stream path is combinational while streaming and is forced low in every other state.
  assign bus.sel_tvalid     = streaming && bus.up_tvalid;
  assign bus.up_tready      = streaming && bus.sel_tready;
  assign bus.cmd_ready      = (state == S_IDLE);
  assign bus.busy           = (state != S_IDLE);
  assign bus.channel_select = select_q;
  assign bus.done           = done_q;
  assign bus.done_channel   = done_ch_q;
  assign bus.beats_xferred  = count_q;
  assign bus.err_timeout    = err_to_q;
  assign bus.err_aborted    = err_ab_q;
  assign bus.err_cmd        = err_cmd_q;
  assign bus.state          = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      ch_q      <= '0;
      done_ch_q <= '0;
      target_q  <= '0;
      count_q   <= '0;
      stall_q   <= '0;
      select_q  <= '0;
      done_q    <= 1'b0;
      err_to_q  <= 1'b0;
      err_ab_q  <= 1'b0;
      err_cmd_q <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      err_to_q  <= 1'b0;
      err_ab_q  <= 1'b0;
      err_cmd_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.cmd_valid) begin
            if (cmd_bad) begin
              err_cmd_q <= 1'b1;
            end else begin
              ch_q     <= bus.cmd_channel;
              target_q <= bus.cmd_beats;
              count_q  <= '0;
              stall_q  <= '0;
              select_q <= NUM_CH'(1) << bus.cmd_channel;
              state    <= S_ARM;
            end
          end
        end
        S_ARM: begin
          if (bus.abort) begin
            state     <= S_DONE;
            select_q  <= '0;
            done_q    <= 1'b1;
            done_ch_q <= ch_q;
            err_ab_q  <= 1'b1;
          end else begin
            state <= S_STREAM;
          end
        end
        S_STREAM: begin
          if (beat) begin
            count_q <= count_inc;
            stall_q <= '0;
          end else begin
            stall_q <= stall_inc;
          end
          // A beat that completes the load wins over an abort in the same cycle.
          if (last_beat || timeout_hit || bus.abort) begin
            state     <= S_DONE;
            select_q  <= '0;
            done_q    <= 1'b1;
            done_ch_q <= ch_q;
            err_to_q  <= timeout_hit;
            err_ab_q  <= bus.abort && !last_beat;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_axis_channel_load_sequencer.sv
// Directed and randomized loads against a burst-level outcome model of the channel load sequencer.
module tb_axis_channel_load_sequencer;
  localparam int NUM_CH  = 16;
  localparam int CH_W    = 4;
  localparam int BEAT_W  = 16;
  localparam int TIMEOUT = 8;
  localparam int TO_W    = 20;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  // Per-stream-cycle stimulus for the load being run; past the end, idle inputs are assumed.
  bit stim_v[$];
  bit stim_r[$];
  bit stim_a[$];

  axis_channel_load_sequencer_if #(.NUM_CH(NUM_CH), .CH_W(CH_W), .BEAT_W(BEAT_W)) bus ();

  axis_channel_load_sequencer #(
    .NUM_CH(NUM_CH), .CH_W(CH_W), .BEAT_W(BEAT_W), .TIMEOUT(TIMEOUT), .TO_W(TO_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Clock and reset
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, n_checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Outcome model: walk the stimulus a beat at a time and decide how the load ends.
  // end_idx is the stream cycle whose edge finishes the load (-1: aborted while arming).
  task automatic predict(input int beats, input bit arm_abort,
                         output int end_idx, output int cnt, output bit to, output bit ab);
    int  stall;
    bit  v, r, a;
    cnt = 0; stall = 0; to = 1'b0; ab = 1'b0; end_idx = -1;
    if (arm_abort) begin
      ab = 1'b1;
      return;
    end
    for (int i = 0; i < 10000; i++) begin
      v = (i < stim_v.size()) ? stim_v[i] : 1'b0;
      r = (i < stim_r.size()) ? stim_r[i] : 1'b0;
      a = (i < stim_a.size()) ? stim_a[i] : 1'b0;
      if (v && r) begin
        cnt++;
        if (cnt == beats) begin
          end_idx = i;
          return;
        end
        stall = 0;
      end else begin
        stall++;
      end
      to = (TIMEOUT != 0) && (stall == TIMEOUT);
      ab = a;
      if (to || ab) begin
        end_idx = i;
        return;
      end
    end
  endtask

  task automatic idle_inputs();
    bus.cmd_valid   = 1'b0;
    bus.cmd_channel = '0;
    bus.cmd_beats   = '0;
    bus.abort       = 1'b0;
    bus.up_tvalid   = 1'b0;
    bus.sel_tready  = 1'b0;
  endtask

  // Driver: issue one command, play the stimulus, check every cycle through DONE and back to IDLE.
  task automatic run_load(input int ch, input int beats, input bit arm_abort, input bit cmd_abort);
    int          end_idx, cnt, seen;
    bit          to, ab, v, r, a;
    logic [15:0] exp_sel;
    predict(beats, arm_abort, end_idx, cnt, to, ab);
    exp_sel = 16'd1 << ch;
    seen = 0;

    @(negedge clk);
    bus.cmd_channel = CH_W'(ch);
    bus.cmd_beats   = BEAT_W'(beats);
    bus.cmd_valid   = 1'b1;
    bus.abort       = cmd_abort;
    bus.up_tvalid   = 1'b1;
    bus.sel_tready  = 1'b1;
    #1;
    check("idle_cmd_ready", bus.cmd_ready, 1);
    check("idle_busy", bus.busy, 0);
    check("idle_select", bus.channel_select, 0);
    check("idle_up_tready", bus.up_tready, 0);

    @(negedge clk);
    bus.cmd_valid = 1'b0;
    bus.abort     = arm_abort;
    #1;
    check("arm_select", bus.channel_select, exp_sel);
    check("arm_busy", bus.busy, 1);
    check("arm_up_tready", bus.up_tready, 0);
    check("arm_sel_tvalid", bus.sel_tvalid, 0);
    check("arm_cmd_ready", bus.cmd_ready, 0);
    check("arm_count", bus.beats_xferred, 0);

    for (int i = 0; i <= end_idx; i++) begin
      v = (i < stim_v.size()) ? stim_v[i] : 1'b0;
      r = (i < stim_r.size()) ? stim_r[i] : 1'b0;
      a = (i < stim_a.size()) ? stim_a[i] : 1'b0;
      @(negedge clk);
      bus.up_tvalid  = v;
      bus.sel_tready = r;
      bus.abort      = a;
      #1;
      check("stream_sel_tvalid", bus.sel_tvalid, v);
      check("stream_up_tready", bus.up_tready, r);
      check("stream_select", bus.channel_select, exp_sel);
      check("stream_count", bus.beats_xferred, seen);
      check("stream_done", bus.done, 0);
      if (v && r) seen++;
    end

    @(negedge clk);
    bus.up_tvalid  = 1'b1;
    bus.sel_tready = 1'b1;
    bus.abort      = 1'($urandom_range(0, 1));
    #1;
    check("done_pulse", bus.done, 1);
    check("done_channel", bus.done_channel, ch);
    check("done_count", bus.beats_xferred, cnt);
    check("done_err_timeout", bus.err_timeout, to);
    check("done_err_aborted", bus.err_aborted, ab);
    check("done_select", bus.channel_select, 0);
    check("done_up_tready", bus.up_tready, 0);
    check("done_sel_tvalid", bus.sel_tvalid, 0);
    check("done_cmd_ready", bus.cmd_ready, 0);

    @(negedge clk);
    idle_inputs();
    #1;
    check("after_busy", bus.busy, 0);
    check("after_done", bus.done, 0);
    check("after_cmd_ready", bus.cmd_ready, 1);
    check("after_count_hold", bus.beats_xferred, cnt);
    check("after_err_flags", {bus.err_timeout, bus.err_aborted}, 0);
  endtask

  task automatic bad_cmd(input int ch);
    @(negedge clk);
    bus.cmd_channel = CH_W'(ch);
    bus.cmd_beats   = '0;
    bus.cmd_valid   = 1'b1;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    #1;
    check("errcmd_pulse", bus.err_cmd, 1);
    check("errcmd_busy", bus.busy, 0);
    check("errcmd_select", bus.channel_select, 0);
    check("errcmd_cmd_ready", bus.cmd_ready, 1);
    @(negedge clk);
    #1;
    check("errcmd_one_cycle", bus.err_cmd, 0);
  endtask

  task automatic fill(input int n, input bit v, input bit r);
    stim_v.delete(); stim_r.delete(); stim_a.delete();
    for (int i = 0; i < n; i++) begin
      stim_v.push_back(v);
      stim_r.push_back(r);
      stim_a.push_back(1'b0);
    end
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    #12;
    check("reset_select", bus.channel_select, 0);
    check("reset_busy", bus.busy, 0);
    check("reset_done", bus.done, 0);
    check("reset_count", bus.beats_xferred, 0);
    @(negedge clk);
    rst = 1'b0;

    // Full-rate load into channel 3.
    fill(4, 1'b1, 1'b1);
    run_load(3, 4, 1'b0, 1'b0);

    // Router ready toggling on channel 15.
    fill(20, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) stim_r[i] = (i % 2 == 0);
    run_load(15, 10, 1'b0, 1'b0);

    // Rejected zero-beat command, then a single-beat load on channel 0.
    bad_cmd(7);
    fill(1, 1'b1, 1'b1);
    run_load(0, 1, 1'b0, 1'b0);

    // Two beats then upstream goes idle until the stall timeout.
    fill(2, 1'b1, 1'b1);
    run_load(6, 5, 1'b0, 1'b0);

    // Abort on the third of six beats, then abort on the last beat.
    fill(6, 1'b1, 1'b1);
    stim_a[2] = 1'b1;
    run_load(9, 6, 1'b0, 1'b0);
    fill(6, 1'b1, 1'b1);
    stim_a[5] = 1'b1;
    run_load(9, 6, 1'b0, 1'b0);

    // Abort while arming, and abort alongside the command in IDLE.
    fill(4, 1'b1, 1'b1);
    run_load(12, 4, 1'b1, 1'b0);
    fill(3, 1'b1, 1'b1);
    run_load(2, 3, 1'b0, 1'b1);

    // Asynchronous reset in the middle of a stream.
    @(negedge clk);
    bus.cmd_channel = 4'd5;
    bus.cmd_beats   = 16'd20;
    bus.cmd_valid   = 1'b1;
    @(negedge clk);
    bus.cmd_valid  = 1'b0;
    bus.up_tvalid  = 1'b1;
    bus.sel_tready = 1'b1;
    repeat (3) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("rst_select", bus.channel_select, 0);
    check("rst_up_tready", bus.up_tready, 0);
    check("rst_sel_tvalid", bus.sel_tvalid, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_count", bus.beats_xferred, 0);
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();
    fill(2, 1'b1, 1'b1);
    run_load(11, 2, 1'b0, 1'b0);

    // Randomized loads.
    for (int t = 0; t < 25; t++) begin
      int n;
      n = $urandom_range(1, 30);
      stim_v.delete(); stim_r.delete(); stim_a.delete();
      for (int i = 0; i < n; i++) begin
        stim_v.push_back($urandom_range(0, 9) < 7);
        stim_r.push_back($urandom_range(0, 9) < 7);
        stim_a.push_back($urandom_range(0, 24) == 0);
      end
      run_load($urandom_range(0, NUM_CH - 1), $urandom_range(1, 12),
               $urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
